// File: rtl/sub8_approx_pkg.sv
// Shared constants and reference functions for the approximate 8-bit subtractor.
// Used by the RTL core and by the bench scoreboard.
package sub8_approx_pkg;

    localparam int unsigned SUB_WIDTH      = 8;
    localparam int unsigned SUB_APPROX_LSB = 4;

    typedef logic [SUB_WIDTH-1:0] operand_t;
    typedef logic [SUB_WIDTH:0]   diff_t;
    typedef logic [SUB_WIDTH+1:0] err_t;

    // Low bits by XOR, high bits exact with a borrow guessed from the top approximate bit.
    function automatic diff_t approx_sub(input operand_t a, input operand_t b);
        logic                               bs;
        logic [SUB_WIDTH-SUB_APPROX_LSB:0]  hi;
        bs = ~a[SUB_APPROX_LSB-1] & b[SUB_APPROX_LSB-1];
        hi = {1'b0, a[SUB_WIDTH-1:SUB_APPROX_LSB]} - {1'b0, b[SUB_WIDTH-1:SUB_APPROX_LSB]}
             - {{(SUB_WIDTH-SUB_APPROX_LSB){1'b0}}, bs};
        return {hi, a[SUB_APPROX_LSB-1:0] ^ b[SUB_APPROX_LSB-1:0]};
    endfunction

    function automatic diff_t exact_sub(input operand_t a, input operand_t b);
        return {1'b0, a} - {1'b0, b};
    endfunction

endpackage

// File: rtl/sub8_approx_core.sv
// Combinational approximate and exact difference of two unsigned operands.
module sub8_approx_core
    import sub8_approx_pkg::*;
#(
    parameter int unsigned WIDTH      = SUB_WIDTH,
    parameter int unsigned APPROX_LSB = SUB_APPROX_LSB
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   d,
    output logic [WIDTH:0]   e
);

    localparam int unsigned HW = WIDTH - APPROX_LSB;

    logic        bs;
    logic [HW:0] hi;

    // Speculative borrow: assume the approximate low part borrowed iff its MSB would.
    assign bs = ~a[APPROX_LSB-1] & b[APPROX_LSB-1];
    assign hi = {1'b0, a[WIDTH-1:APPROX_LSB]} - {1'b0, b[WIDTH-1:APPROX_LSB]}
                - {{HW{1'b0}}, bs};
    assign d  = {hi, a[APPROX_LSB-1:0] ^ b[APPROX_LSB-1:0]};
    assign e  = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/sub8_approx_pipe.sv
// Two-stage valid/ready pipeline around the approximate subtractor core, with
// per-result error magnitude and saturating running error statistics.
module sub8_approx_pipe
    import sub8_approx_pkg::*;
#(
    parameter int unsigned WIDTH      = SUB_WIDTH,
    parameter int unsigned APPROX_LSB = SUB_APPROX_LSB,
    parameter int unsigned STAT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH:0]    out_d,
    output logic [WIDTH+1:0]  out_err,
    input  logic              stat_clear,
    output logic [STAT_W-1:0] stat_count,
    output logic [STAT_W-1:0] stat_err_sum,
    output logic [WIDTH+1:0]  stat_wce
);

    logic [WIDTH:0]   core_d, core_e;
    logic             s1_valid_q, s2_valid_q;
    logic [WIDTH:0]   s1_d_q, s1_e_q, s2_d_q;
    logic [WIDTH+1:0] s2_err_q;
    logic             s1_ready, s2_ready;
    logic [WIDTH+1:0] err_diff, s1_err;

    logic [STAT_W-1:0] count_q, count_d, err_sum_q, err_sum_d;
    logic [WIDTH+1:0]  wce_q, wce_d;
    logic [STAT_W:0]   sum_ext;
    logic              out_hs;

    sub8_approx_core #(
        .WIDTH      (WIDTH),
        .APPROX_LSB (APPROX_LSB)
    ) u_core (
        .a (in_a),
        .b (in_b),
        .d (core_d),
        .e (core_e)
    );

    assign s2_ready = ~s2_valid_q | out_ready;
    assign s1_ready = ~s1_valid_q | s2_ready;
    assign in_ready = s1_ready;

    // Both values sign-extended to WIDTH+2 so the difference cannot overflow.
    always_comb begin
        err_diff = {s1_e_q[WIDTH], s1_e_q} - {s1_d_q[WIDTH], s1_d_q};
        s1_err   = err_diff[WIDTH+1] ? (~err_diff + 1'b1) : err_diff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_d_q     <= '0;
            s1_e_q     <= '0;
        end else if (s1_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_d_q <= core_d;
                s1_e_q <= core_e;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_d_q     <= '0;
            s2_err_q   <= '0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_d_q   <= s1_d_q;
                s2_err_q <= s1_err;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_d     = s2_d_q;
    assign out_err   = s2_err_q;

    assign out_hs  = s2_valid_q & out_ready;
    assign sum_ext = {1'b0, err_sum_q} + {{(STAT_W-WIDTH-1){1'b0}}, s2_err_q};

    // Clear wins over a coincident handshake; that result is dropped from the stats.
    always_comb begin
        count_d   = count_q;
        err_sum_d = err_sum_q;
        wce_d     = wce_q;
        if (stat_clear) begin
            count_d   = '0;
            err_sum_d = '0;
            wce_d     = '0;
        end else if (out_hs) begin
            if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
            err_sum_d = sum_ext[STAT_W] ? '1 : sum_ext[STAT_W-1:0];
            if (s2_err_q > wce_q) begin
                wce_d = s2_err_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            err_sum_q <= '0;
            wce_q     <= '0;
        end else begin
            count_q   <= count_d;
            err_sum_q <= err_sum_d;
            wce_q     <= wce_d;
        end
    end

    assign stat_count   = count_q;
    assign stat_err_sum = err_sum_q;
    assign stat_wce     = wce_q;

endmodule

// File: tb/tb_sub8_approx_pipe.sv
// Scoreboard bench for sub8_approx_pipe: directed ops, streaming, backpressure,
// statistics clear, mid-flight reset and an exhaustive shuffled sweep.
module tb_sub8_approx_pipe;
    import sub8_approx_pkg::*;

    typedef struct packed {
        logic [8:0] d;
        logic [9:0] err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, stat_clear;
    logic [7:0]  in_a, in_b;
    logic [8:0]  out_d;
    logic [9:0]  out_err, stat_wce;
    logic [31:0] stat_count, stat_err_sum;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned acc_cnt  = 0;
    int unsigned pop_cnt  = 0;
    int unsigned cyc      = 0;
    int unsigned m_count, m_sum, m_wce;
    bit          rand_rdy = 1'b0;
    exp_t        sb_q[$];
    logic [15:0] perm[65536];

    logic [7:0] ta[5] = '{8'h10, 8'h05, 8'h00, 8'h00, 8'hFF};
    logic [7:0] tb[5] = '{8'h01, 8'h03, 8'h08, 8'h01, 8'hFF};
    logic [8:0] td[5] = '{9'h011, 9'h006, 9'h1F8, 9'h001, 9'h000};
    logic [9:0] te[5] = '{10'd2, 10'd4, 10'd0, 10'd2, 10'd0};

    sub8_approx_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_d        (out_d),
        .out_err      (out_err),
        .stat_clear   (stat_clear),
        .stat_count   (stat_count),
        .stat_err_sum (stat_err_sum),
        .stat_wce     (stat_wce)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #3;
        if (rand_rdy) out_ready = ($urandom_range(15, 0) != 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    endtask

    function automatic exp_t make_exp(input logic [7:0] a, input logic [7:0] b);
        diff_t d, e;
        int    ds, es, diff;
        exp_t  r;
        d    = approx_sub(a, b);
        e    = exact_sub(a, b);
        ds   = d[8] ? int'(d) - 512 : int'(d);
        es   = e[8] ? int'(e) - 512 : int'(e);
        diff = es - ds;
        r.d   = d;
        r.err = 10'(diff < 0 ? -diff : diff);
        return r;
    endfunction

    // Scoreboard and statistics model, sampled away from the active edge.
    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            sb_q.delete();
            m_count = 0;
            m_sum   = 0;
            m_wce   = 0;
        end else begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check("out_d", out_d, sb_q[0].d);
                    check("out_err", out_err, sb_q[0].err);
                    if (out_ready) begin
                        x = sb_q.pop_front();
                        pop_cnt++;
                        if (!stat_clear) begin
                            m_count++;
                            m_sum += x.err;
                            if (x.err > m_wce) m_wce = x.err;
                        end
                    end
                end
            end
            if (stat_clear) begin
                m_count = 0;
                m_sum   = 0;
                m_wce   = 0;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(make_exp(in_a, in_b));
                acc_cnt++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b);
        bit done = 1'b0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            check("send_timeout", 32'd0, 32'd1);
            finish_tb();
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(posedge clk);
            #1;
            done = (sb_q.size() == 0) && !out_valid;
        end
        check("drain", {31'd0, done}, 32'd1);
        if (!done) finish_tb();
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_count"}, stat_count, m_count);
        check({tag, "_sum"}, stat_err_sum, m_sum);
        check({tag, "_wce"}, {22'd0, stat_wce}, m_wce);
    endtask

    initial begin
        int unsigned c0, a0, p0;
        logic [15:0] t;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b1; stat_clear = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_d", {23'd0, out_d}, 32'd0);
        check("rst_out_err", {22'd0, out_err}, 32'd0);
        check("rst_count", stat_count, 32'd0);
        check("rst_sum", stat_err_sum, 32'd0);
        check("rst_wce", {22'd0, stat_wce}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Single ops: result visible two edges after the drive.
        for (int i = 0; i < 5; i++) begin
            check("single_in_ready", {31'd0, in_ready}, 32'd1);
            in_a = ta[i]; in_b = tb[i]; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            check("lat_valid", {31'd0, out_valid}, 32'd1);
            check("lat_d", {23'd0, out_d}, {23'd0, td[i]});
            check("lat_err", {22'd0, out_err}, {22'd0, te[i]});
            @(posedge clk); #1;
        end
        check("single_count", stat_count, 32'd5);
        check("single_sum", stat_err_sum, 32'd8);
        check("single_wce", {22'd0, stat_wce}, 32'd4);

        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        check_stats("idle_clear");

        // Back-to-back stream: last result leaves exactly 7 edges after the first drive.
        c0 = cyc;
        for (int i = 0; i < 5; i++) send(ta[i], tb[i]);
        wait_drain(20);
        check("stream_cycles", cyc - c0, 32'd7);
        check("stream_count", stat_count, 32'd5);
        check("stream_sum", stat_err_sum, 32'd8);
        check("stream_wce", {22'd0, stat_wce}, 32'd4);

        // Backpressure: out_ready low for 6 cycles while 6 ops are offered.
        a0 = acc_cnt; p0 = pop_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(8'($urandom), 8'($urandom));
            end
            begin
                @(posedge clk); @(posedge clk); #2;
                check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                check("bp_accepts", acc_cnt - a0, 32'd2);
                repeat (4) @(posedge clk);
                #2;
                check("bp_still_full", {30'd0, out_valid, in_ready}, 32'd2);
                out_ready = 1'b1;
            end
        join
        wait_drain(30);
        check("bp_total_in", acc_cnt - a0, 32'd6);
        check("bp_total_out", pop_cnt - p0, 32'd6);
        check_stats("bp");

        // Clear coinciding with an output handshake.
        send(8'h05, 8'h03);
        @(posedge clk); #1;
        check("clr_hs_valid", {30'd0, out_valid, out_ready}, 32'd3);
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        check("clr_count", stat_count, 32'd0);
        check("clr_sum", stat_err_sum, 32'd0);
        check("clr_wce", {22'd0, stat_wce}, 32'd0);
        check_stats("clr_model");

        // Reset with two results in flight.
        send(8'h10, 8'h01);
        wait_drain(10);
        check("pre_rst_count", stat_count, 32'd1);
        out_ready = 1'b0;
        send(8'h05, 8'h03);
        send(8'h00, 8'h01);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_count", stat_count, 32'd0);
        check("arst_sum", stat_err_sum, 32'd0);
        check("arst_wce", {22'd0, stat_wce}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        send(8'h05, 8'h03);
        wait_drain(10);
        check("post_rst_count", stat_count, 32'd1);
        check("post_rst_sum", stat_err_sum, 32'd4);

        // Exhaustive sweep in shuffled order under random backpressure.
        stat_clear = 1'b1;
        @(posedge clk); #1;
        stat_clear = 1'b0;
        for (int i = 0; i < 65536; i++) perm[i] = 16'(i);
        for (int i = 65535; i > 0; i--) begin
            int j;
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        rand_rdy = 1'b1;
        for (int i = 0; i < 65536; i++) send(perm[i][15:8], perm[i][7:0]);
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        wait_drain(50);
        check("exh_count", stat_count, 32'd65536);
        check_stats("exh");

        finish_tb();
    end

endmodule
